// File: rtl/fast_vram_pkg.sv
// Shared definitions for the fast VRAM sprite Y-parse scheduler and its helpers.
package fast_vram_pkg;

    // Default sizing of the sprite attribute area and the per-line active list.
    localparam int NUM_SPRITES_DEF = 381;
    localparam int ACTIVE_MAX_DEF  = 96;
    localparam int IDX_W_DEF       = 9;

    // Fast VRAM address prefixes: attribute area and active-list area.
    localparam logic [1:0] PARSE_BASE  = 2'b01;
    localparam logic [2:0] ACTIVE_BASE = 3'b110;

    // Field layout of the attribute word {Y[8:0], CHAIN, SIZE[5:0]}.
    localparam int Y_MSB     = 15;
    localparam int Y_LSB     = 7;
    localparam int CHAIN_BIT = 6;
    localparam int SIZE_MSB  = 5;
    localparam int SIZE_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARSE,
        ST_WRITE,
        ST_CPU,
        ST_DONE
    } state_t;

endpackage

// File: rtl/parse_y_match.sv
// Combinational Y/size window test of one sprite against the lookahead line.
// Shared with the renderer checker, so it carries no state.
module parse_y_match (
    input  logic [7:0] RASTERC,
    input  logic       FLIP,
    input  logic [8:0] Y,
    input  logic [4:0] SIZE,
    output logic       MATCH
);

    logic [7:0] w_la;
    logic [8:0] w_add_y;
    logic       w_n;
    logic [5:0] w_sum;

    // Lookahead two lines ahead (FLIP stands in for the raster LSB), then the size window carry.
    always_comb begin
        w_la    = 8'd2 + {RASTERC[7:1], FLIP};
        w_add_y = {1'b0, w_la} + {1'b0, Y[7:0]};
        w_n     = ~(w_add_y[8] ^ Y[8]);
        w_sum   = {1'b0, w_n, ~w_add_y[7:4]} + {1'b0, SIZE};
        MATCH   = w_sum[5];
    end

endmodule

// File: rtl/fast_vram_parse_sched.sv
// Per-scanline Y-parse scheduler: walks the sprite attribute area, fills the
// ping-pong active list and slots single-cycle CPU accesses between parse steps.
module fast_vram_parse_sched
    import fast_vram_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int ACTIVE_MAX  = ACTIVE_MAX_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             PARSE_INDEX_INC_CLK,
    input  logic             RESETP,
    input  logic             NEW_LINE,
    input  logic [7:0]       RASTERC,
    input  logic             FLIP,
    input  logic [15:0]      FVRAM_RD_DATA,
    input  logic             CPU_REQ,
    output logic [IDX_W+1:0] PARSE_ADDR,
    output logic             ACT_WE,
    output logic [10:0]      ACT_WR_ADDR,
    output logic [IDX_W-1:0] ACT_WR_DATA,
    output logic             RD_BANK,
    output logic             CPU_GNT,
    output logic             PARSING,
    output logic             DONE,
    output logic             FULL,
    output logic [6:0]       ACTIVE_COUNT
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [6:0]       CNT_MAX  = 7'(ACTIVE_MAX);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_index, w_index_next;
    logic             r_prev_active, w_prev_next;
    logic             r_wr_bank, w_bank_next;
    logic [6:0]       r_act_count, w_count_next;
    logic             r_full, w_full_next;
    logic             r_act_we, w_we_next;
    logic [IDX_W-1:0] r_act_wr_data, w_wr_data_next;
    logic [10:0]      r_act_wr_addr, w_wr_addr_next;
    logic             r_cpu_gnt, w_gnt_next;
    logic [IDX_W+1:0] r_parse_addr;
    logic             r_parsing;
    logic             r_done;

    logic             w_match;
    logic             w_active;

    parse_y_match u_y_match (
        .RASTERC (RASTERC),
        .FLIP    (FLIP),
        .Y       (FVRAM_RD_DATA[Y_MSB:Y_LSB]),
        .SIZE    (FVRAM_RD_DATA[SIZE_MSB-1:SIZE_LSB]),
        .MATCH   (w_match)
    );

    // A chained sprite follows its predecessor; otherwise window match or forced-on size bit.
    assign w_active = FVRAM_RD_DATA[CHAIN_BIT] ? r_prev_active
                                               : (w_match | FVRAM_RD_DATA[SIZE_MSB]);

    // Next-state and next-output decode; NEW_LINE overrides every state.
    always_comb begin
        // NOTE: every next value is defaulted first so no path leaves it unassigned and no latch is inferred.
        w_state_next   = r_state;
        w_index_next   = r_index;
        w_prev_next    = r_prev_active;
        w_bank_next    = r_wr_bank;
        w_count_next   = r_act_count;
        w_full_next    = r_full;
        w_we_next      = 1'b0;
        w_wr_data_next = r_act_wr_data;
        w_wr_addr_next = r_act_wr_addr;
        w_gnt_next     = 1'b0;

        if (NEW_LINE) begin
            w_state_next = ST_PARSE;
            w_index_next = '0;
            w_prev_next  = 1'b0;
            w_bank_next  = ~r_wr_bank;
            w_count_next = '0;
            w_full_next  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    w_gnt_next = CPU_REQ & ~r_cpu_gnt;
                end
                ST_PARSE: begin
                    if (CPU_REQ) begin
                        w_state_next = ST_CPU;
                        w_gnt_next   = 1'b1;
                    end else if (w_active) begin
                        w_state_next   = ST_WRITE;
                        w_prev_next    = 1'b1;
                        w_we_next      = 1'b1;
                        w_wr_data_next = r_index;
                        w_wr_addr_next = {ACTIVE_BASE, r_wr_bank, r_act_count};
                    end else begin
                        w_prev_next = 1'b0;
                        if (r_index == LAST_IDX) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_index_next = r_index + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    w_count_next = r_act_count + 7'd1;
                    if (w_count_next == CNT_MAX) begin
                        w_full_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end else if (r_index == LAST_IDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_index_next = r_index + 1'b1;
                        w_state_next = ST_PARSE;
                    end
                end
                ST_CPU: begin
                    w_state_next = ST_PARSE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset returns everything to idle immediately.
    always_ff @(posedge PARSE_INDEX_INC_CLK or negedge RESETP) begin
        if (!RESETP) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_prev_active <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_act_count   <= '0;
            r_full        <= 1'b0;
            r_act_we      <= 1'b0;
            r_act_wr_data <= '0;
            r_act_wr_addr <= '0;
            r_cpu_gnt     <= 1'b0;
            r_parse_addr  <= '0;
            r_parsing     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
            r_state       <= w_state_next;
            r_index       <= w_index_next;
            r_prev_active <= w_prev_next;
            r_wr_bank     <= w_bank_next;
            r_act_count   <= w_count_next;
            r_full        <= w_full_next;
            r_act_we      <= w_we_next;
            r_act_wr_data <= w_wr_data_next;
            r_act_wr_addr <= w_wr_addr_next;
            r_cpu_gnt     <= w_gnt_next;
            r_parse_addr  <= {PARSE_BASE, w_index_next};
            r_parsing     <= (w_state_next == ST_PARSE) || (w_state_next == ST_WRITE);
            r_done        <= (w_state_next == ST_DONE);
        end
    end

    assign PARSE_ADDR   = r_parse_addr;
    assign ACT_WE       = r_act_we;
    assign ACT_WR_ADDR  = r_act_wr_addr;
    assign ACT_WR_DATA  = r_act_wr_data;
    assign RD_BANK      = ~r_wr_bank;
    assign CPU_GNT      = r_cpu_gnt;
    assign PARSING      = r_parsing;
    assign DONE         = r_done;
    assign FULL         = r_full;
    assign ACTIVE_COUNT = r_act_count;

endmodule

// File: tb/tb_fast_vram_parse_sched.sv
// Scoreboard bench for the sprite Y-parse scheduler: directed lines push the
// expected active-list writes, a monitor pops and compares on every ACT_WE.
module tb_fast_vram_parse_sched;

    logic        clk;
    logic        rst_n;
    logic        new_line;
    logic [7:0]  rasterc;
    logic        flip;
    logic [15:0] rd_data;
    logic        cpu_req;
    logic [10:0] parse_addr;
    logic        act_we;
    logic [10:0] act_wr_addr;
    logic [8:0]  act_wr_data;
    logic        rd_bank;
    logic        cpu_gnt;
    logic        parsing;
    logic        done;
    logic        full;
    logic [6:0]  active_count;

    logic [15:0] mem [0:380];
    logic        exp_bank;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [10:0] addr;
        logic [8:0]  data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  got;
    logic prev_we;

    fast_vram_parse_sched dut (
        .PARSE_INDEX_INC_CLK (clk),
        .RESETP              (rst_n),
        .NEW_LINE            (new_line),
        .RASTERC             (rasterc),
        .FLIP                (flip),
        .FVRAM_RD_DATA       (rd_data),
        .CPU_REQ             (cpu_req),
        .PARSE_ADDR          (parse_addr),
        .ACT_WE              (act_we),
        .ACT_WR_ADDR         (act_wr_addr),
        .ACT_WR_DATA         (act_wr_data),
        .RD_BANK             (rd_bank),
        .CPU_GNT             (cpu_gnt),
        .PARSING             (parsing),
        .DONE                (done),
        .FULL                (full),
        .ACTIVE_COUNT        (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attribute memory answers in the same cycle as the address.
    assign rd_data = (parse_addr[8:0] <= 9'd380) ? mem[parse_addr[8:0]] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] attr(input logic [8:0] y, input logic chain, input logic [5:0] size);
        return {y, chain, size};
    endfunction

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 381; i++) mem[i] = v;
    endtask

    task automatic expect_wr(input int idx, input int slot);
        wr_t e;
        logic [6:0] s;
        s      = slot[6:0];
        e.addr = {3'b110, exp_bank, s};
        e.data = idx[8:0];
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; the pulse is seen by the next rising edge.
    task automatic pulse_new_line();
        new_line = 1'b1;
        exp_bank = ~exp_bank;
        @(negedge clk);
        new_line = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [10:0] a);
        int n;
        n = 0;
        while (parse_addr !== a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, {21'b0, parse_addr}, {21'b0, a});
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        check(name, exp_q.size(), 32'd0);
    endtask

    // Monitor: every active-list write must match the next expected entry and last one cycle.
    always @(negedge clk) begin
        if (rst_n && act_we) begin
            check("act_we_single_cycle", {31'b0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_act_we: got write data=%0d addr=0x%0h, expected no write",
                         act_wr_data, act_wr_addr);
            end else begin
                got = exp_q.pop_front();
                check("act_wr_data", {23'b0, act_wr_data}, {23'b0, got.data});
                check("act_wr_addr", {21'b0, act_wr_addr}, {21'b0, got.addr});
            end
        end
        prev_we = rst_n & act_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n    = 1'b0;
        new_line = 1'b0;
        rasterc  = 8'd100;
        flip     = 1'b0;
        cpu_req  = 1'b0;
        exp_bank = 1'b0;
        prev_we  = 1'b0;
        fill(attr(9'd0, 1'b0, 6'h00));

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_parse_addr", {21'b0, parse_addr}, 32'h0);
        check("rst_act_we", {31'b0, act_we}, 32'd0);
        check("rst_act_wr_addr", {21'b0, act_wr_addr}, 32'h0);
        check("rst_rd_bank", {31'b0, rd_bank}, 32'd1);
        check("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        check("rst_parsing", {31'b0, parsing}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_count", {25'b0, active_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU slot granted from IDLE, one cycle only.
        cpu_req = 1'b1;
        @(negedge clk);
        check("idle_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("idle_not_parsing", {31'b0, parsing}, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("idle_gnt_drop", {31'b0, cpu_gnt}, 32'd0);

        // Line with nothing active: DONE 381 cycles after NEW_LINE, bank swap.
        pulse_new_line();
        check("t1_rd_bank", {31'b0, rd_bank}, 32'd0);
        check("t1_parsing", {31'b0, parsing}, 32'd1);
        wait_done("t1", cyc);
        check("t1_done_cycles", cyc, 32'd381);
        check("t1_count", {25'b0, active_count}, 32'd0);
        check("t1_full", {31'b0, full}, 32'd0);
        check("t1_parsing_end", {31'b0, parsing}, 32'd0);
        cpu_req = 1'b1;
        @(negedge clk);
        check("done_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("done_hold", {31'b0, done}, 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("done_gnt_drop", {31'b0, cpu_gnt}, 32'd0);

        // Every sprite forced active: list fills at 96 entries, indexes 0..95.
        fill(attr(9'd0, 1'b0, 6'h20));
        pulse_new_line();
        for (int i = 0; i < 96; i++) expect_wr(i, i);
        wait_done("t3", cyc);
        check("t3_full", {31'b0, full}, 32'd1);
        check("t3_count", {25'b0, active_count}, 32'd96);
        drain("t3_drained");

        // Chain rules: index 0 chain inherits 0 (even after a full line), 5 forced, 6-7 chained.
        fill(attr(9'd0, 1'b0, 6'h00));
        mem[0]   = attr(9'd0, 1'b1, 6'h00);
        mem[5]   = attr(9'd0, 1'b0, 6'h20);
        mem[6]   = attr(9'd0, 1'b1, 6'h00);
        mem[7]   = attr(9'd0, 1'b1, 6'h00);
        mem[100] = attr(9'd0, 1'b1, 6'h00);
        pulse_new_line();
        check("t2_full_cleared", {31'b0, full}, 32'd0);
        expect_wr(5, 0);
        expect_wr(6, 1);
        expect_wr(7, 2);
        wait_done("t2", cyc);
        check("t2_count", {25'b0, active_count}, 32'd3);
        drain("t2_drained");

        // CPU request at index 40: grant, index held, then sprite 40 is still written.
        fill(attr(9'd0, 1'b0, 6'h00));
        mem[40] = attr(9'd0, 1'b0, 6'h20);
        pulse_new_line();
        expect_wr(40, 0);
        wait_addr("t4_reach_40", 11'h228);
        cpu_req = 1'b1;
        @(negedge clk);
        check("t4_gnt", {31'b0, cpu_gnt}, 32'd1);
        check("t4_addr_in_gnt", {21'b0, parse_addr}, 32'h228);
        cpu_req = 1'b0;
        @(negedge clk);
        check("t4_gnt_drop", {31'b0, cpu_gnt}, 32'd0);
        check("t4_addr_after_gnt", {21'b0, parse_addr}, 32'h228);
        @(negedge clk);
        check("t4_write_40", {31'b0, act_we}, 32'd1);
        wait_done("t4", cyc);
        check("t4_count", {25'b0, active_count}, 32'd1);
        drain("t4_drained");

        // NEW_LINE at index 200 aborts the line; sprite 200 only written on the new line.
        fill(attr(9'd0, 1'b0, 6'h00));
        mem[10]  = attr(9'd0, 1'b0, 6'h20);
        mem[200] = attr(9'd0, 1'b0, 6'h20);
        pulse_new_line();
        expect_wr(10, 0);
        wait_addr("t5_reach_200", 11'h2C8);
        check("t5_count_before", {25'b0, active_count}, 32'd1);
        pulse_new_line();
        check("t5_index_cleared", {21'b0, parse_addr}, 32'h200);
        check("t5_count_cleared", {25'b0, active_count}, 32'd0);
        check("t5_rd_bank", {31'b0, rd_bank}, {31'b0, ~exp_bank});
        check("t5_no_we", {31'b0, act_we}, 32'd0);
        expect_wr(10, 0);
        expect_wr(200, 1);
        wait_done("t5", cyc);
        check("t5_count", {25'b0, active_count}, 32'd2);
        drain("t5_drained");

        // Reset mid-parse clears everything at once.
        fill(attr(9'd0, 1'b0, 6'h00));
        pulse_new_line();
        wait_addr("rst_reach_50", 11'h232);
        rst_n = 1'b0;
        #1;
        check("mid_rst_parsing", {31'b0, parsing}, 32'd0);
        check("mid_rst_addr", {21'b0, parse_addr}, 32'h0);
        check("mid_rst_rd_bank", {31'b0, rd_bank}, 32'd1);
        exp_bank = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'b0, parsing}, 32'd0);

        // Window arithmetic: Y=0x1F0 with SIZE 2 matches, SIZE 0 does not; FLIP moves the lookahead.
        rasterc = 8'h10;
        flip    = 1'b0;
        fill(attr(9'd0, 1'b0, 6'h00));
        mem[0] = attr(9'h1F0, 1'b0, 6'h02);
        mem[1] = attr(9'h1F0, 1'b0, 6'h00);
        mem[2] = attr(9'h0FD, 1'b0, 6'h11);
        pulse_new_line();
        expect_wr(0, 0);
        expect_wr(2, 1);
        wait_done("t6a", cyc);
        check("t6a_count", {25'b0, active_count}, 32'd2);
        drain("t6a_drained");
        flip = 1'b1;
        pulse_new_line();
        expect_wr(0, 0);
        wait_done("t6b", cyc);
        check("t6b_count", {25'b0, active_count}, 32'd1);
        drain("t6b_drained");

        // FULL coincides with the last index: sprites 285..380 active.
        rasterc = 8'd100;
        flip    = 1'b0;
        fill(attr(9'd0, 1'b0, 6'h00));
        for (int i = 285; i < 381; i++) mem[i] = attr(9'd0, 1'b0, 6'h20);
        pulse_new_line();
        for (int i = 285; i < 381; i++) expect_wr(i, i - 285);
        wait_done("tlast", cyc);
        check("tlast_full", {31'b0, full}, 32'd1);
        check("tlast_count", {25'b0, active_count}, 32'd96);
        drain("tlast_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fast_vram_parse_sched.md
Name: fast_vram_parse_sched

Overview:
- Per-scanline Y-parse scheduler for the fast VRAM sprite attribute area.
- Walks sprite indexes 0..NUM_SPRITES-1, evaluates the Y/size match and the chain rule, and writes matching indexes into the ping-pong active list.
- Stops on end-of-list or active-list-full, and inserts single-cycle CPU access slots between parse steps.
- Sits between the raster/pixel timing logic and the fast VRAM address/data mux.

Parameters:
- NUM_SPRITES, 381, number of sprite entries parsed per line.
- ACTIVE_MAX, 96, active-list capacity per line.
- IDX_W, 9, parse index width.

Ports:
- PARSE_INDEX_INC_CLK  in  1  block clock; all state changes on its rising edge.
- RESETP  in  1  asynchronous, active-low reset.
- NEW_LINE  in  1  synchronous one-cycle start-of-line pulse.
- RASTERC  in  8  current raster line, low 8 bits.
- FLIP  in  1  screen flip; replaces RASTERC[0] in the lookahead.
- FVRAM_RD_DATA  in  16  {Y[8:0], CHAIN, SIZE[5:0]} for the address on PARSE_ADDR, valid same cycle.
- CPU_REQ  in  1  CPU requests a fast VRAM slot; held until granted.
- PARSE_ADDR  out  11  {2'b01, index}.
- ACT_WE  out  1  active-list write strobe.
- ACT_WR_ADDR  out  11  {3'b110, wr_bank, slot[6:0]}.
- ACT_WR_DATA  out  9  sprite index being written.
- RD_BANK  out  1  bank the renderer reads; always ~wr_bank.
- CPU_GNT  out  1  one-cycle CPU slot grant.
- PARSING  out  1  high in PARSE or WRITE.
- DONE  out  1  parse finished for this line.
- FULL  out  1  active list reached ACTIVE_MAX.
- ACTIVE_COUNT  out  7  entries written this line.

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, wr_bank 0. RD_BANK=1 because it is ~wr_bank.
- States: IDLE, PARSE, WRITE, CPU, DONE. All outputs are registered.
- NEW_LINE has top priority in every state. On NEW_LINE:
  - toggle wr_bank;
  - clear index, ACTIVE_COUNT, FULL, DONE and prev_active;
  - go to PARSE next cycle.
- A NEW_LINE arriving mid-parse aborts the current line. No pending write is issued.

Match arithmetic (combinational, per PARSE cycle):
- la = 8'd2 + {RASTERC[7:1], FLIP}, 8-bit, wraps.
- add_y = la + Y[7:0], 9-bit.
- n = ~(add_y[8] ^ Y[8]).
- sum = {n, ~add_y[7:4]} + SIZE[4:0], 6-bit.
- match = sum[5].
- active = CHAIN ? prev_active : (match | SIZE[5]).

PARSE:
- If CPU_REQ: go to CPU. index and prev_active hold; nothing is evaluated this cycle.
- Else if active: go to WRITE, latch index into ACT_WR_DATA, set prev_active=1.
- Else: set prev_active=0. If index==NUM_SPRITES-1 go to DONE, otherwise index+1.

WRITE:
- ACT_WE=1 for exactly one cycle; slot = ACTIVE_COUNT; ACTIVE_COUNT+1.
- If the new count == ACTIVE_MAX: FULL=1, go to DONE.
- Else if index==NUM_SPRITES-1: go to DONE.
- Else: index+1, go to PARSE.

CPU:
- CPU_GNT=1 for one cycle, then return to PARSE with the same index. The CPU is never starved for more than one WRITE cycle.

IDLE/DONE:
- CPU_REQ is granted the next cycle (CPU_GNT pulse); state stays put.
- DONE=1 holds until NEW_LINE or reset.

Boundaries:
- FULL and last index coinciding: DONE with FULL=1.
- ACTIVE_COUNT never exceeds ACTIVE_MAX.
- index never exceeds NUM_SPRITES-1.
- A chain sprite at index 0 inherits prev_active=0.
- Reset asserted mid-parse returns all state to reset values immediately.

Decomposition:
- Shared package fast_vram_pkg:
  - state enum;
  - address prefix constants PARSE_BASE=2'b01, ACTIVE_BASE=3'b110;
  - NUM_SPRITES/ACTIVE_MAX defaults;
  - field offsets of the Y word.
- One combinational sub-module, parse_y_match: inputs RASTERC, FLIP, Y, SIZE; output match. It is reused by the renderer checker.

Test Plan:
1. Reset then NEW_LINE, all sprites Y=0, SIZE=0, RASTERC=100 -> no ACT_WE; DONE after 381 cycles; ACTIVE_COUNT=0; RD_BANK=0, wr_bank=1.
2. Sprite 5 with SIZE[5]=1, sprites 6-7 CHAIN=1, others inactive -> ACT_WE writes data 5,6,7 to slots 0,1,2 at ACT_WR_ADDR 0x680..0x682 (wr_bank=1); ACTIVE_COUNT=3.
3. All sprites SIZE[5]=1 -> exactly 96 writes, slots 0..95; the last write carries index 95; FULL=1, DONE=1; no 97th ACT_WE.
4. CPU_REQ asserted mid-PARSE at index 40 -> CPU_GNT one cycle; PARSE_ADDR stays 0x228 across the grant; parse resumes at 40 with no skipped index.
5. NEW_LINE at index 200 -> next cycle index=0, ACTIVE_COUNT=0, wr_bank toggles; no ACT_WE from the aborted line.
6. Y=0x1F0, SIZE=0x02, RASTERC=0x10, FLIP=0 -> parse_y_match gives match=1 and the sprite is written. SIZE=0x00 with the same Y/raster -> not written.
